lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer between the MEM pipeline stage and a single-ported, word-wide, byte-enabled data memory with a request/grant/response handshake.
- Registers each load or store, generates byte enables and lane-shifted write data, and stalls the pipeline until the access completes.
- Splits misaligned halfword/word accesses into two word beats.
- Merges and sign/zero-extends load data.

Parameters:
- None. Address and data are fixed at 32 bits (RV32I).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- MemReadM  input  1  load request from MEM stage; held stable while StallM=1
- MemWriteM  input  1  store request; held stable while StallM=1
- funct3M  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALUResultM  input  32  byte address
- WriteDataM  input  32  store data, right-justified
- StallM  output  1  freeze IF..MEM stages
- ReadDataM  output  32  extended load result
- memReq  output  1  memory request
- memWe  output  1  1=write beat
- memAddr  output  32  word-aligned beat address, bits[1:0]=00
- memBe  output  4  byte enables for the beat
- memWdata  output  32  lane-aligned write data
- memGnt  input  1  request accepted this cycle
- memRvalid  input  1  one response per granted beat; loads and stores
- memRdata  input  32  read data, valid with memRvalid

Behaviour:
- Reset (synchronous, active-high): state=IDLE. memReq, memWe, memBe, memAddr, memWdata and ReadDataM all 0. StallM follows its equation below (0 when no request is present).
- Op = MemWriteM | MemReadM. If both are set, it is a store.
- Legal funct3: stores 000/001/010; loads 000/001/010/100/101.
- Illegal funct3: no memory traffic and no stall; ReadDataM is unchanged.
- StallM = (IDLE & legal Op) | (state ∉ {IDLE, DONE}). Combinational.
- States:
  - IDLE: on legal Op, latch addr, funct3, data and write flag; go to ISSUE0.
  - ISSUE0: drive beat 0. On memGnt → WAIT0.
  - WAIT0: on memRvalid, capture rdata0, then → ISSUE1 if split, else → DONE.
  - ISSUE1: drive beat 1. On memGnt → WAIT1.
  - WAIT1: on memRvalid, capture rdata1 → DONE.
  - DONE: StallM=0 and ReadDataM is valid; next cycle → IDLE.
- memReq=1 only in ISSUE0/ISSUE1. memWe, memAddr, memBe and memWdata are held stable until memGnt, and are 0 outside ISSUE states.
- memRvalid outside WAIT0/WAIT1 is ignored.
- Size mask: b=0001, h=0011, w=1111. off=addr[1:0].
- mask8 = sizeMask << off (8 bits). be0 = mask8[3:0]; be1 = mask8[7:4]. split = (be1 != 0).
- Beat 0: addr = {addr[31:2],00}, data = (WriteDataM << 8*off)[31:0].
- Beat 1: addr = beat-0 addr + 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000). data = WriteDataM >> 8*(4-off).
- Loads drive the same memBe as stores.
- Load result: raw = ({rdata1, rdata0} >> 8*off)[31:0], with rdata1=0 if not split.
  - lb/lh: sign-extend from bit 7/15. lbu/lhu: zero-extend. lw: raw.
  - ReadDataM is registered on entry to DONE and holds until the next load's DONE. Stores leave it unchanged.
- Zero-wait memory (gnt in the issue cycle, rvalid the next cycle):
  - aligned access: StallM high for 3 cycles, DONE on the 4th;
  - split access: StallM high for 5 cycles.
- Reset mid-operation: abandon immediately, memReq drops the same cycle reset is sampled, return to IDLE. Responses to abandoned beats are not expected, because the memory is reset by the same signal.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, zero-wait memory → one beat: addr 0x100, be 1111, wdata 0xDEADBEEF, memWe=1. StallM high 3 cycles then low.
- sb addr 0x102, data 0x000000A5 → one beat: addr 0x100, be 0100, wdata 0x00A50000.
- lh addr 0x203; mem[0x200]=0x80112233, mem[0x204]=0x445566FF → two beats (0x200 be 1000, then 0x204 be 0001). ReadDataM=0xFFFFFF80. lhu same access → 0x0000FF80.
- sw addr 0xFFFFFFFE, data 0x11223344 → beat 0 addr 0xFFFFFFFC be 1100 wdata 0x33440000; beat 1 addr 0x00000000 be 0011 wdata 0x00001122.
- memGnt withheld 3 cycles on lw 0x10 → memReq/memAddr/memBe stable throughout. memRvalid arriving 2 cycles after grant extends the stall by exactly 1 cycle.
- Edge cases:
  - reset asserted in WAIT0 of a split store → next cycle IDLE, memReq=0, ReadDataM=0, and no beat 1 is issued;
  - store with funct3=011 → StallM=0 and no memReq.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a single-ported, byte-enabled
// word memory. Each access is registered, issued as one or two word beats
// over a req/gnt/rvalid handshake, and the pipeline is stalled until the
// access completes. Load data is merged across beats and sign/zero-extended.
module lsu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] read_data_q, read_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Request decode: a store wins when both request lines are set.
  logic store_legal, load_legal, legal_op;
  assign store_legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
  assign load_legal  = store_legal || (funct3M == 3'b100) || (funct3M == 3'b101);
  assign legal_op    = MemWriteM ? store_legal : (MemReadM && load_legal);

  // In IDLE the beat geometry comes straight from the MEM stage so beat 0 can
  // be registered on the same edge that latches the request; afterwards it
  // comes from the latched copy.
  logic        in_idle;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_funct3;
  logic        cur_we;
  assign in_idle    = (state_q == S_IDLE);
  assign cur_addr   = in_idle ? ALUResultM : addr_q;
  assign cur_wdata  = in_idle ? WriteDataM : wdata_q;
  assign cur_funct3 = in_idle ? funct3M    : funct3_q;
  assign cur_we     = in_idle ? MemWriteM  : we_q;

  // Beat geometry: byte-enable split across two words and lane-shifted data.
  logic [3:0]  size_mask, be0, be1;
  logic [7:0]  mask8;
  logic [4:0]  lane_shamt;
  logic [5:0]  hi_shamt;
  logic [31:0] beat0_addr, beat1_addr, wdata_lo, wdata_hi;
  logic        split;
  always_comb begin
    unique case (cur_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    mask8      = {4'b0000, size_mask} << cur_addr[1:0];
    be0        = mask8[3:0];
    be1        = mask8[7:4];
    split      = |be1;
    lane_shamt = {cur_addr[1:0], 3'b000};
    hi_shamt   = 6'd32 - {1'b0, lane_shamt};
    beat0_addr = {cur_addr[31:2], 2'b00};
    beat1_addr = beat0_addr + 32'd4;
    wdata_lo   = cur_wdata << lane_shamt;
    wdata_hi   = cur_wdata >> hi_shamt;
  end

  // Load result: merge the response words, realign, then extend by size/sign.
  logic [31:0] rd_hi, rd_lo, raw, load_result;
  always_comb begin
    rd_hi = (state_q == S_WAIT1) ? memRdata : 32'h0;
    rd_lo = (state_q == S_WAIT1) ? rdata0_q : memRdata;
    raw   = 32'({rd_hi, rd_lo} >> lane_shamt);
    unique case (funct3_q)
      3'b000:  load_result = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_result = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_result = {24'h0, raw[7:0]};
      3'b101:  load_result = {16'h0, raw[15:0]};
      default: load_result = raw;
    endcase
  end

  // Next-state logic for the sequencer and the registered memory-side outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata0_d    = rdata0_q;
    read_data_d = read_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (legal_op) begin
          state_d  = S_ISSUE0;
          addr_d   = ALUResultM;
          funct3_d = funct3M;
          wdata_d  = WriteDataM;
          we_d     = MemWriteM;
        end
      end
      S_ISSUE0: if (memGnt) state_d = S_WAIT0;
      S_WAIT0: begin
        if (memRvalid) begin
          rdata0_d = memRdata;
          if (split) begin
            state_d = S_ISSUE1;
          end else begin
            state_d = S_DONE;
            if (!we_q) read_data_d = load_result;
          end
        end
      end
      S_ISSUE1: if (memGnt) state_d = S_WAIT1;
      S_WAIT1: begin
        if (memRvalid) begin
          state_d = S_DONE;
          if (!we_q) read_data_d = load_result;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'h0;
    mem_be_d    = 4'b0000;
    mem_wdata_d = 32'h0;
    if (state_d == S_ISSUE0) begin
      mem_req_d   = 1'b1;
      mem_we_d    = cur_we;
      mem_addr_d  = beat0_addr;
      mem_be_d    = be0;
      mem_wdata_d = wdata_lo;
    end else if (state_d == S_ISSUE1) begin
      mem_req_d   = 1'b1;
      mem_we_d    = cur_we;
      mem_addr_d  = beat1_addr;
      mem_be_d    = be1;
      mem_wdata_d = wdata_hi;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      funct3_q    <= 3'b000;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      rdata0_q    <= 32'h0;
      read_data_q <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rdata0_q    <= rdata0_d;
      read_data_q <= read_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign StallM    = (in_idle && legal_op) || !((state_q == S_IDLE) || (state_q == S_DONE));
  assign ReadDataM = read_data_q;
  assign memReq    = mem_req_q;
  assign memWe     = mem_we_q;
  assign memAddr   = mem_addr_q;
  assign memBe     = mem_be_q;
  assign memWdata  = mem_wdata_q;

endmodule
